// File: rtl/ciq_pkg.sv
// Shared types and sizing for the 16-entry integer issue queue back end.
package ciq_pkg;

    localparam int CIQ_ENTRIES = 16;
    localparam int CIQ_IDX_W   = 4;
    localparam int PTAG_W      = 6;
    localparam int ALLOC_N     = 4;
    localparam int WAKE_N      = 2;
    localparam int PAYLOAD_W   = 32;
    localparam int LANE_W      = 2;

    typedef struct packed {
        logic                 valid;
        logic                 pending;
        logic [PTAG_W-1:0]    src1_tag;
        logic                 src1_rdy;
        logic [PTAG_W-1:0]    src2_tag;
        logic                 src2_rdy;
        logic [PAYLOAD_W-1:0] payload;
    } ciq_entry_t;

    typedef enum logic {ISS_EMPTY, ISS_FULL} iss_state_t;

endpackage

// File: rtl/ciq_age_matrix.sv
// Pairwise age matrix: older_q[i][j]=1 means slot i is older than slot j.
// Oldest-of-request output is combinational from registered age bits.
module ciq_age_matrix
    import ciq_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [CIQ_ENTRIES-1:0]        alloc_hit,
    input  logic [CIQ_ENTRIES*LANE_W-1:0] alloc_lane,
    input  logic [CIQ_ENTRIES-1:0]        keep,
    input  logic [CIQ_ENTRIES-1:0]        req,
    output logic [CIQ_ENTRIES-1:0]        oldest
);

    logic [CIQ_ENTRIES-1:0][CIQ_ENTRIES-1:0] older_q, older_d;

    always_comb begin
        older_d = older_q;
        for (int i = 0; i < CIQ_ENTRIES; i++) begin
            for (int j = 0; j < CIQ_ENTRIES; j++) begin
                if (i == j || flush) begin
                    older_d[i][j] = 1'b0;
                end else if (alloc_hit[i] && alloc_hit[j]) begin
                    // same-cycle allocations: lower lane is older
                    older_d[i][j] = alloc_lane[i*LANE_W +: LANE_W] < alloc_lane[j*LANE_W +: LANE_W];
                end else if (alloc_hit[i]) begin
                    older_d[i][j] = 1'b0;
                end else if (alloc_hit[j]) begin
                    older_d[i][j] = keep[i];
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < CIQ_ENTRIES; i++) begin
            oldest[i] = req[i];
            for (int j = 0; j < CIQ_ENTRIES; j++) begin
                if (req[j] && older_q[j][i]) oldest[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) older_q <= '0;
        else        older_q <= older_d;
    end

endmodule

// File: rtl/ciq_issue_select.sv
// CIQ entry array, tag wakeup, oldest-ready select into a registered issue slot.
// Alloc-to-issue_valid is 2 edges; issue slot holds its uop while issue_ready is low.
module ciq_issue_select
    import ciq_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ALLOC_N-1:0]           alloc_en,
    input  logic [ALLOC_N*CIQ_IDX_W-1:0] alloc_addr,
    input  logic [ALLOC_N*PTAG_W-1:0]    alloc_src1_tag,
    input  logic [ALLOC_N*PTAG_W-1:0]    alloc_src2_tag,
    input  logic [ALLOC_N-1:0]           alloc_src1_rdy,
    input  logic [ALLOC_N-1:0]           alloc_src2_rdy,
    input  logic [ALLOC_N*PAYLOAD_W-1:0] alloc_payload,
    input  logic [WAKE_N-1:0]            wake_valid,
    input  logic [WAKE_N*PTAG_W-1:0]     wake_tag,
    input  logic                         flush,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [CIQ_IDX_W-1:0]         issue_addr,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [CIQ_ENTRIES-1:0]       ciq_free,
    output logic [CIQ_IDX_W:0]           ciq_count
);

    ciq_entry_t                    ent_q [CIQ_ENTRIES];
    ciq_entry_t                    ent_d [CIQ_ENTRIES];
    iss_state_t                    state_q, state_d;
    logic [CIQ_IDX_W-1:0]          issue_addr_q, issue_addr_d;
    logic [PAYLOAD_W-1:0]          issue_payload_q, issue_payload_d;
    logic [CIQ_ENTRIES-1:0]        ciq_free_q, ciq_free_d;
    logic [CIQ_IDX_W:0]            ciq_count_q, ciq_count_d;

    logic [CIQ_ENTRIES-1:0]        alloc_hit, cand, win, keep;
    logic [CIQ_ENTRIES*LANE_W-1:0] alloc_lane;
    logic [CIQ_IDX_W-1:0]          win_idx;
    logic                          win_any, leave, load;

    function automatic logic woken(input logic [PTAG_W-1:0] tag,
                                   input logic [WAKE_N-1:0] wv,
                                   input logic [WAKE_N*PTAG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_N; w++) begin
            if (wv[w] && wt[w*PTAG_W +: PTAG_W] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        alloc_hit  = '0;
        alloc_lane = '0;
        for (int k = 0; k < ALLOC_N; k++) begin
            if (alloc_en[k]) begin
                alloc_hit[alloc_addr[k*CIQ_IDX_W +: CIQ_IDX_W]] = 1'b1;
                alloc_lane[alloc_addr[k*CIQ_IDX_W +: CIQ_IDX_W]*LANE_W +: LANE_W] = LANE_W'(k);
            end
        end
    end

    assign leave = (state_q == ISS_FULL) && issue_ready;

    always_comb begin
        for (int i = 0; i < CIQ_ENTRIES; i++) begin
            cand[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy & ~ent_q[i].pending;
            keep[i] = ent_q[i].valid & ~(leave && issue_addr_q == CIQ_IDX_W'(i));
        end
    end

    ciq_age_matrix u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .alloc_hit  (alloc_hit),
        .alloc_lane (alloc_lane),
        .keep       (keep),
        .req        (cand),
        .oldest     (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < CIQ_ENTRIES; i++) begin
            if (win[i]) win_idx = CIQ_IDX_W'(i);
        end
    end
    assign win_any = |win;

    always_comb begin
        state_d         = state_q;
        issue_addr_d    = issue_addr_q;
        issue_payload_d = issue_payload_q;
        load            = 1'b0;
        case (state_q)
            ISS_EMPTY: load = win_any;
            ISS_FULL: begin
                if (issue_ready) begin
                    if (win_any) load = 1'b1;
                    else         state_d = ISS_EMPTY;
                end
            end
            default: state_d = ISS_EMPTY;
        endcase
        if (load) begin
            state_d         = ISS_FULL;
            issue_addr_d    = win_idx;
            issue_payload_d = ent_q[win_idx].payload;
        end
        if (flush) state_d = ISS_EMPTY;
    end

    always_comb begin
        ciq_count_d = '0;
        for (int i = 0; i < CIQ_ENTRIES; i++) begin
            logic [LANE_W-1:0] ln;
            ln       = alloc_lane[i*LANE_W +: LANE_W];
            ent_d[i] = ent_q[i];
            if (woken(ent_q[i].src1_tag, wake_valid, wake_tag)) ent_d[i].src1_rdy = 1'b1;
            if (woken(ent_q[i].src2_tag, wake_valid, wake_tag)) ent_d[i].src2_rdy = 1'b1;
            if (leave && issue_addr_q == CIQ_IDX_W'(i)) begin
                ent_d[i].valid   = 1'b0;
                ent_d[i].pending = 1'b0;
            end
            if (load && win_idx == CIQ_IDX_W'(i)) ent_d[i].pending = 1'b1;
            if (alloc_hit[i]) begin
                // wake bypass so a broadcast in the alloc cycle is not lost
                ent_d[i].valid    = 1'b1;
                ent_d[i].pending  = 1'b0;
                ent_d[i].src1_tag = alloc_src1_tag[ln*PTAG_W +: PTAG_W];
                ent_d[i].src2_tag = alloc_src2_tag[ln*PTAG_W +: PTAG_W];
                ent_d[i].src1_rdy = alloc_src1_rdy[ln] | woken(alloc_src1_tag[ln*PTAG_W +: PTAG_W], wake_valid, wake_tag);
                ent_d[i].src2_rdy = alloc_src2_rdy[ln] | woken(alloc_src2_tag[ln*PTAG_W +: PTAG_W], wake_valid, wake_tag);
                ent_d[i].payload  = alloc_payload[ln*PAYLOAD_W +: PAYLOAD_W];
            end
            if (flush) begin
                ent_d[i].valid   = 1'b0;
                ent_d[i].pending = 1'b0;
            end
            ciq_free_d[i] = ~ent_d[i].valid;
            ciq_count_d   = ciq_count_d + (CIQ_IDX_W+1)'(ent_d[i].valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CIQ_ENTRIES; i++) ent_q[i] <= '0;
            state_q         <= ISS_EMPTY;
            issue_addr_q    <= '0;
            issue_payload_q <= '0;
            ciq_free_q      <= '1;
            ciq_count_q     <= '0;
        end else begin
            for (int i = 0; i < CIQ_ENTRIES; i++) ent_q[i] <= ent_d[i];
            state_q         <= state_d;
            issue_addr_q    <= issue_addr_d;
            issue_payload_q <= issue_payload_d;
            ciq_free_q      <= ciq_free_d;
            ciq_count_q     <= ciq_count_d;
        end
    end

    assign issue_valid   = (state_q == ISS_FULL);
    assign issue_addr    = issue_addr_q;
    assign issue_payload = issue_payload_q;
    assign ciq_free      = ciq_free_q;
    assign ciq_count     = ciq_count_q;

    for (genvar k = 0; k < ALLOC_N; k++) begin : g_alloc_chk
        a_alloc_free: assert property (@(posedge clk) disable iff (!rst_n)
            alloc_en[k] |-> !ent_q[alloc_addr[k*CIQ_IDX_W +: CIQ_IDX_W]].valid);
        for (genvar m = k + 1; m < ALLOC_N; m++) begin : g_pair
            a_alloc_distinct: assert property (@(posedge clk) disable iff (!rst_n)
                (alloc_en[k] && alloc_en[m]) |->
                (alloc_addr[k*CIQ_IDX_W +: CIQ_IDX_W] != alloc_addr[m*CIQ_IDX_W +: CIQ_IDX_W]));
        end
    end

endmodule
